// File: rtl/regif_acc_rw.sv
// -----------------------------------------------------------------------------
// regif_acc_rw
//
// Services one host register access (read or write) at a time on the REGIF
// master bus and returns a {status, data} word to the host.
//
// Host side
//   acc_addr / acc_data / acc_wr  access descriptor, latched while waiting
//   acc_en / acc_en_ack           request level from the host, with a one-cycle accept pulse
//   snd_resp / snd_resp_ack       response valid level and consumed level (slow domain)
//   resp                          {status[31:0], data[DW-1:0]}
// REGIF side
//   IP2Bus_MstRd_Req / IP2Bus_MstWr_Req  command strobes, held until CmdAck
//   IP2Bus_Mst_Addr / IP2Bus_MstWr_d     address and write data
//   Bus2IP_Mst_CmdAck / Cmplt / Error    command accept, completion, and error (valid with Cmplt)
//   Bus2IP_MstRd_d / src_rdy_n           read data beat, valid when src_rdy_n is low
//   my_regif / drv_regif                 bus grant and ownership claim
// -----------------------------------------------------------------------------
module regif_acc_rw #(
    parameter int          DW          = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT     = 1024,
    parameter int          WR_RESP     = 1,
    parameter logic [31:0] ACK_CODE    = 32'h1,
    parameter logic [31:0] NACK_CODE   = 32'h2,
    parameter logic [31:0] TMO_CODE    = 32'h3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      acc_addr,
    input  logic [DW-1:0]    acc_data,
    input  logic             acc_wr,
    input  logic             acc_en,
    output logic             acc_en_ack,
    output logic             IP2Bus_MstRd_Req,
    output logic             IP2Bus_MstWr_Req,
    output logic [31:0]      IP2Bus_Mst_Addr,
    output logic [DW-1:0]    IP2Bus_MstWr_d,
    input  logic             Bus2IP_Mst_CmdAck,
    input  logic             Bus2IP_Mst_Cmplt,
    input  logic             Bus2IP_Mst_Error,
    input  logic [DW-1:0]    Bus2IP_MstRd_d,
    input  logic             Bus2IP_MstRd_src_rdy_n,
    output logic             snd_resp,
    input  logic             snd_resp_ack,
    output logic [31+DW:0]   resp,
    input  logic             my_regif,
    output logic             drv_regif
);

    // Timeout counter width; a single unused bit when the timeout is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_WAITEN = 7'b0000010,
        S_ARB    = 7'b0000100,
        S_REQ    = 7'b0001000,
        S_BUS    = 7'b0010000,
        S_RESP   = 7'b0100000,
        S_HOLD   = 7'b1000000
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic [31:0]            addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   got_q, got_d;
    logic [CW-1:0]          tmo_q, tmo_d;
    logic [31:0]            st_q, st_d;
    logic [DW-1:0]          dat_q, dat_d;

    logic                   acc_en_ack_d;
    logic                   rd_req_d, wr_req_d;
    logic [31:0]            mst_addr_d;
    logic [DW-1:0]          mst_wd_d;
    logic                   drv_d, snd_d;
    logic [31+DW:0]         resp_d;

    // NOTE: next-state logic assigns a default to every signal first, so no path
    // through the case statement leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        en_sync_d    = '0;
        ack_sync_d   = '0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        rdata_d      = rdata_q;
        got_d        = got_q;
        tmo_d        = tmo_q;
        st_d         = st_q;
        dat_d        = dat_q;
        acc_en_ack_d = 1'b0;
        rd_req_d     = IP2Bus_MstRd_Req;
        wr_req_d     = IP2Bus_MstWr_Req;
        mst_addr_d   = IP2Bus_Mst_Addr;
        mst_wd_d     = IP2Bus_MstWr_d;
        drv_d        = drv_regif;
        snd_d        = snd_resp;
        resp_d       = resp;

        unique case (state_q)
            S_IDLE: begin
                // Synchronisers stay cleared here (default) so no stale level survives.
                drv_d      = 1'b0;
                mst_addr_d = '0;
                mst_wd_d   = '0;
                state_d    = S_WAITEN;
            end

            S_WAITEN: begin
                // acc_en is only looked at while waiting; elsewhere its chain is held clear.
                en_sync_d = (en_sync_q << 1) | SYNC_STAGES'(acc_en);
                addr_d    = acc_addr;
                wdata_d   = acc_data;
                wr_d      = acc_wr;
                if (en_sync_q[SYNC_STAGES-1]) begin
                    acc_en_ack_d = 1'b1;
                    state_d      = S_ARB;
                end
            end

            S_ARB: begin
                if (my_regif) begin
                    drv_d   = 1'b1;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                mst_addr_d = addr_q;
                mst_wd_d   = wdata_q;
                rd_req_d   = ~wr_q;
                wr_req_d   = wr_q;
                tmo_d      = CW'(TIMEOUT);
                rdata_d    = '0;
                got_d      = 1'b0;
                state_d    = S_BUS;
            end

            S_BUS: begin
                if (Bus2IP_Mst_CmdAck) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                end
                // A beat in the completion cycle is folded in before the status is formed.
                if (!Bus2IP_MstRd_src_rdy_n) begin
                    rdata_d = Bus2IP_MstRd_d;
                    got_d   = 1'b1;
                end
                if (Bus2IP_Mst_Cmplt) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = S_RESP;
                    if (Bus2IP_Mst_Error) begin
                        st_d  = NACK_CODE;
                        dat_d = wr_q ? '0 : rdata_d;
                    end else if (!wr_q && !got_d) begin
                        st_d  = NACK_CODE;
                        dat_d = '0;
                    end else begin
                        st_d  = ACK_CODE;
                        dat_d = wr_q ? '0 : rdata_d;
                    end
                end else if (TIMEOUT != 0) begin
                    if (tmo_q == CW'(1)) begin
                        rd_req_d = 1'b0;
                        wr_req_d = 1'b0;
                        st_d     = TMO_CODE;
                        dat_d    = '0;
                        state_d  = S_RESP;
                    end else begin
                        tmo_d = tmo_q - CW'(1);
                    end
                end
            end

            S_RESP: begin
                drv_d = 1'b0;
                if (wr_q && (WR_RESP == 0)) begin
                    state_d = S_IDLE;
                end else begin
                    resp_d  = {st_q, dat_q};
                    snd_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                ack_sync_d = (ack_sync_q << 1) | SYNC_STAGES'(snd_resp_ack);
                if (ack_sync_q[SYNC_STAGES-1]) begin
                    snd_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            en_sync_q        <= '0;
            ack_sync_q       <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wr_q             <= 1'b0;
            rdata_q          <= '0;
            got_q            <= 1'b0;
            tmo_q            <= '0;
            st_q             <= '0;
            dat_q            <= '0;
            acc_en_ack       <= 1'b0;
            IP2Bus_MstRd_Req <= 1'b0;
            IP2Bus_MstWr_Req <= 1'b0;
            IP2Bus_Mst_Addr  <= '0;
            IP2Bus_MstWr_d   <= '0;
            drv_regif        <= 1'b0;
            snd_resp         <= 1'b0;
            resp             <= '0;
        end else begin
            state_q          <= state_d;
            en_sync_q        <= en_sync_d;
            ack_sync_q       <= ack_sync_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            wr_q             <= wr_d;
            rdata_q          <= rdata_d;
            got_q            <= got_d;
            tmo_q            <= tmo_d;
            st_q             <= st_d;
            dat_q            <= dat_d;
            acc_en_ack       <= acc_en_ack_d;
            IP2Bus_MstRd_Req <= rd_req_d;
            IP2Bus_MstWr_Req <= wr_req_d;
            IP2Bus_Mst_Addr  <= mst_addr_d;
            IP2Bus_MstWr_d   <= mst_wd_d;
            drv_regif        <= drv_d;
            snd_resp         <= snd_d;
            resp             <= resp_d;
        end
    end

endmodule

// File: doc/regif_acc_rw.md
Name: regif_acc_rw

Overview:
- Parametrised successor to the host read-access engine.
- Services one host register access at a time from tlp2regif, either read or write, on the REGIF master bus.
- Adds write support, configurable data width, configurable synchroniser depth, a bus timeout with its own response code, and optional write responses.
- Returns a status+data word to regif2tlp and arbitrates for REGIF through the my_regif/drv_regif pair.

Parameters:
DW, 32, REGIF data width; legal values 32 or 64.
SYNC_STAGES, 2, flops on acc_en and snd_resp_ack (1..4).
TIMEOUT, 1024, cycles allowed from request assertion to Bus2IP_Mst_Cmplt; 0 disables the timeout.
WR_RESP, 1, 1 = writes produce a response; 0 = writes complete silently.
ACK_CODE, 32'h1, status for a successful access.
NACK_CODE, 32'h2, status for a bus error.
TMO_CODE, 32'h3, status for a timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
acc_addr  in  32  access address, sampled with acc_en
acc_data  in  DW  write data
acc_wr  in  1  1 = write, 0 = read
acc_en  in  1  access request level, held by host until acc_en_ack
acc_en_ack  out  1  one-cycle acceptance pulse
IP2Bus_MstRd_Req  out  1  REGIF read request
IP2Bus_MstWr_Req  out  1  REGIF write request
IP2Bus_Mst_Addr  out  32  REGIF address
IP2Bus_MstWr_d  out  DW  REGIF write data
Bus2IP_Mst_CmdAck  in  1  command accepted
Bus2IP_Mst_Cmplt  in  1  transfer complete
Bus2IP_Mst_Error  in  1  error, qualified by Cmplt
Bus2IP_MstRd_d  in  DW  read data
Bus2IP_MstRd_src_rdy_n  in  1  read data valid, active low
snd_resp  out  1  response valid level
snd_resp_ack  in  1  response consumed, level from a slow domain
resp  out  32+DW  {status[31:0], data[DW-1:0]}
my_regif  in  1  REGIF grant
drv_regif  out  1  REGIF ownership claim

Behaviour:
Reset values:
- All outputs are 0, the FSM is in IDLE, and all synchroniser flops are 0.
- A reset mid-operation drops both request strobes and drv_regif on the next edge, with no response.
- The synchronisers feed only a rising-edge-free level check. After each use they are cleared so stale levels are not reused.

FSM (one-hot):
- IDLE: clear the synchronisers, drv_regif=0, IP2Bus_Mst_Addr=0. Move to WAITEN.
- WAITEN: latch acc_addr, acc_data and acc_wr every cycle. When synced acc_en=1, pulse acc_en_ack for 1 cycle and go to ARB.
  - Latency from acc_en rising to acc_en_ack is SYNC_STAGES+1 cycles.
- ARB: when my_regif=1, set drv_regif=1 and go to REQ. There is no timeout while waiting for the grant.
- REQ: drive the address and write data. Assert MstRd_Req or MstWr_Req according to acc_wr. Load the timeout counter with TIMEOUT. Go to BUS.
- BUS:
  - The request stays high until the first cycle with CmdAck=1, then drops.
  - Read data is captured on every cycle with src_rdy_n=0, keeping the last beat, and sets a got_data flag.
  - On Cmplt=1: status = Error ? NACK_CODE : ACK_CODE.
    - A read completing with no data beat seen returns NACK_CODE with data 0.
    - Writes return data 0.
    - Go to RESP.
  - Otherwise, if TIMEOUT≠0, decrement the counter. On reaching 0: drop the request, status=TMO_CODE, data=0, go to RESP.
  - If Cmplt and counter-expiry occur in the same cycle, Cmplt wins.
  - src_rdy_n=0 in the same cycle as Cmplt is captured before the response is formed.
- RESP:
  - drv_regif=0 and resp is registered.
  - If the access is a write and WR_RESP=0, go to IDLE.
  - Otherwise set snd_resp=1 and go to HOLD.
- HOLD: resp is stable. When synced snd_resp_ack=1, set snd_resp=0 and go to IDLE.

Further rules:
- A new acc_en is not accepted before returning to IDLE. There is exactly one access in flight.
- The timeout counter is ceil(log2(TIMEOUT+1)) bits wide; TIMEOUT=0 means it is unused.
- DW=64 widens only the data paths. Address and status remain 32 bits.

Test Plan:
1. Read, addr 0x40: bus returns CmdAck then data 0xDEADBEEF with Cmplt, Error=0. Required: MstRd_Req high from REQ until the CmdAck edge; resp={0x1,0xDEADBEEF}; snd_resp held until the synced ack; drv_regif 0 after RESP.
2. Write, addr 0x80, data 0x12345678, WR_RESP=1: Cmplt with Error=1. Required: MstWr_Req asserted with IP2Bus_MstWr_d=0x12345678; resp={0x2,0}.
3. Write with WR_RESP=0: Cmplt with Error=0. Required: snd_resp never asserts; FSM returns to IDLE; the next acc_en is accepted.
4. Timeout with TIMEOUT=16, no Cmplt: request drops and resp={0x3,0} 16 cycles after the REQ cycle. Second case: Cmplt arrives on the expiry cycle. Required: resp={0x1,data}.
5. DW=64 read returning 0x0123456789ABCDEF, and separately a read with Cmplt but no data beat. Required: resp={0x1,0x0123456789ABCDEF}, then resp={0x2,0}.
6. Reset asserted during BUS: next edge all outputs 0; a subsequent read completes normally with the correct acc_en_ack latency (SYNC_STAGES+1).
